svi_sdram_arbiter: RTL and testbench



---
 rtl/svi_sdram_arbiter.sv | 100 ++++++++++
 tb/tb_svi_sdram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svi_sdram_arbiter.sv
// svi_sdram_arbiter: one SDRAM port shared by download, CPU and tape requesters.
// The priority is download > CPU > tape. A tape request that has starved for too long jumps the queue.
module svi_sdram_arbiter #(
    parameter int STARVE_MAX = 64
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_req,
    input  logic [17:0] dl_addr,
    input  logic [7:0]  dl_din,
    output logic        dl_ack,
    input  logic        cpu_rd,
    input  logic        cpu_we,
    input  logic [17:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_wait,
    input  logic        cas_req,
    input  logic [17:0] cas_addr,
    output logic [7:0]  cas_dout,
    output logic        cas_ack,
    output logic [17:0] sd_addr,
    output logic [7:0]  sd_din,
    output logic        sd_we,
    output logic        sd_rd,
    input  logic [7:0]  sd_dout,
    input  logic        sd_ready
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_DL, SRC_CPU, SRC_CAS} src_t;

    state_t     r_state, w_next;
    src_t       r_src, w_gnt;
    logic       r_first, r_we, r_cpu_pend, r_cpu_wr, r_strobe_q;
    logic [7:0] r_starve;
    logic       w_strobe, w_cpu_edge, w_starved, w_done, w_cas_busy;

    assign w_strobe   = cpu_rd | cpu_we;
    assign w_cpu_edge = w_strobe & ~r_strobe_q;
    assign w_starved  = cas_req && (32'(r_starve) >= STARVE_MAX);
    assign w_done     = (r_state == DONE) && !reset;
    assign w_cas_busy = (w_gnt == SRC_CAS) || (r_state != IDLE && r_src == SRC_CAS);

    assign sd_rd    = (r_state == ISSUE) && !r_we && !reset;
    assign sd_we    = (r_state == ISSUE) && r_we && !reset;
    assign dl_ack   = w_done && r_src == SRC_DL;
    assign cas_ack  = w_done && r_src == SRC_CAS;
    assign cpu_wait = !reset && (r_cpu_pend || w_cpu_edge);

    always_comb begin
        w_gnt  = SRC_NONE;
        w_next = r_state;
        if (r_state == IDLE && sd_ready)
            w_gnt = w_starved ? SRC_CAS : dl_req ? SRC_DL : r_cpu_pend ? SRC_CPU : cas_req ? SRC_CAS : SRC_NONE;
        case (r_state)
            IDLE:    w_next = (w_gnt != SRC_NONE) ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (!r_first && sd_ready) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= IDLE;
            r_src      <= SRC_NONE;
            r_first    <= 1'b0;
            r_we       <= 1'b0;
            r_cpu_pend <= 1'b0;
            r_cpu_wr   <= 1'b0;
            r_strobe_q <= w_strobe; // a strobe held across reset must not count as a new access
            r_starve   <= 8'd0;
            cpu_dout   <= 8'hFF;
            cas_dout   <= 8'h00;
            sd_addr    <= 18'd0;
            sd_din     <= 8'd0;
        end else begin
            r_state    <= w_next;
            r_strobe_q <= w_strobe;
            r_first    <= (r_state == ISSUE);
            if (w_gnt != SRC_NONE) begin
                r_src   <= w_gnt;
                r_we    <= (w_gnt == SRC_DL) || (w_gnt == SRC_CPU && r_cpu_wr);
                sd_addr <= (w_gnt == SRC_DL) ? dl_addr : (w_gnt == SRC_CPU) ? cpu_addr : cas_addr;
                sd_din  <= (w_gnt == SRC_DL) ? dl_din : (w_gnt == SRC_CPU) ? cpu_din : 8'h00;
            end
            if (r_state == DONE && r_src == SRC_CPU && !r_we)
                cpu_dout <= sd_dout;
            if (r_state == DONE && r_src == SRC_CAS)
                cas_dout <= sd_dout;
            if (w_cpu_edge) begin
                r_cpu_pend <= 1'b1;
                r_cpu_wr   <= cpu_we;
            end else if (r_state == DONE && r_src == SRC_CPU) begin
                r_cpu_pend <= 1'b0;
            end
            r_starve <= (!cas_req || w_cas_busy) ? 8'd0 : r_starve + {7'd0, r_starve != 8'hFF};
        end
    end
endmodule

// File: tb/tb_svi_sdram_arbiter.sv
// tb_svi_sdram_arbiter: directed tests for the SDRAM arbiter.
// A timestamp-based reference model is compared against the DUT outputs on every cycle.
module tb_svi_sdram_arbiter;
    localparam logic [17:0] DL_BASE = 18'h10000;

    logic        clk_sys = 1'b0, reset = 1'b1;
    logic        dl_req = 1'b0, dl_ack;
    logic [17:0] dl_addr;
    logic [7:0]  dl_din;
    logic        cpu_rd = 1'b0, cpu_we = 1'b0, cpu_wait;
    logic [17:0] cpu_addr = 18'd0;
    logic [7:0]  cpu_din = 8'd0, cpu_dout;
    logic        cas_req = 1'b0, cas_ack;
    logic [17:0] cas_addr = 18'd0;
    logic [7:0]  cas_dout;
    logic [17:0] sd_addr;
    logic [7:0]  sd_din, sd_dout;
    logic        sd_we, sd_rd, sd_ready;

    svi_sdram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ack(dl_ack),
        .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .cas_req(cas_req), .cas_addr(cas_addr), .cas_dout(cas_dout), .cas_ack(cas_ack),
        .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_rd(sd_rd),
        .sd_dout(sd_dout), .sd_ready(sd_ready)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM: busy for 3 cycles after each command, read data is a fixed function of the address
    int busy = 0;
    assign sd_ready = (busy == 0);
    assign sd_dout  = sd_addr[7:0] ^ 8'h91;
    always @(posedge clk_sys) busy <= (sd_rd || sd_we) ? 3 : (busy > 0 ? busy - 1 : 0);

    // download source steps its address on every ack
    int dl_cnt = 0;
    always @(posedge clk_sys) if (dl_ack) dl_cnt <= dl_cnt + 1;
    assign dl_addr = DL_BASE + 18'(dl_cnt);
    assign dl_din  = dl_addr[7:0] ^ 8'h3C;

    int checks = 0, errors = 0, cyc = 0;
    int n_rd = 0, n_we = 0, n_dl = 0, n_cas = 0;
    logic [17:0] iss_addr[$];
    int          iss_cyc[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // reference model: one transfer in flight, identified by its issue and completion cycles
    bit          started = 0, m_act = 0, m_wr = 0, m_pend = 0, m_pend_wr = 0, m_prev = 0;
    int          m_src = 0, m_issue = 0, m_done = -1, m_starve = 0;
    logic [17:0] m_addr = 18'd0;
    logic [7:0]  m_din = 8'd0, m_cpu_dout = 8'hFF, m_cas_dout = 8'h00;

    always @(posedge clk_sys) begin
        bit act0, pend0, edge_now, tape;
        int g;
        if (reset) begin
            m_act = 0; m_addr = 18'd0; m_din = 8'd0; m_pend = 0; m_pend_wr = 0; m_starve = 0;
            m_cpu_dout = 8'hFF; m_cas_dout = 8'h00; m_prev = cpu_rd | cpu_we;
        end else begin
            act0 = m_act;
            pend0 = m_pend;
            edge_now = (cpu_rd | cpu_we) && !m_prev;
            if (m_act && cyc == m_done) begin
                if (m_src == 2 && !m_wr) m_cpu_dout = m_addr[7:0] ^ 8'h91;
                if (m_src == 3) m_cas_dout = m_addr[7:0] ^ 8'h91;
                if (m_src == 2) m_pend = 0;
                m_act = 0;
            end else if (m_act && m_done < 0 && cyc >= m_issue + 2 && sd_ready) begin
                m_done = cyc + 1;
            end
            g = 0;
            if (!act0 && sd_ready)
                g = (cas_req && m_starve >= 64) ? 3 : dl_req ? 1 : pend0 ? 2 : cas_req ? 3 : 0;
            if (g != 0) begin
                m_act = 1; m_src = g; m_issue = cyc + 1; m_done = -1;
                m_wr = (g == 1) || (g == 2 && m_pend_wr);
                m_addr = (g == 1) ? dl_addr : (g == 2) ? cpu_addr : cas_addr;
                m_din = (g == 1) ? dl_din : (g == 2) ? cpu_din : 8'h00;
            end
            tape = (act0 && m_src == 3) || g == 3;
            m_starve = (!cas_req || tape) ? 0 : (m_starve < 255 ? m_starve + 1 : 255);
            if (edge_now) begin
                m_pend = 1;
                m_pend_wr = cpu_we;
            end
            m_prev = cpu_rd | cpu_we;
        end
        cyc++;
        started = 1;
    end

    always @(negedge clk_sys) if (started) begin
        bit iss, dn;
        iss = !reset && m_act && cyc == m_issue;
        dn = !reset && m_act && cyc == m_done;
        chk("sd_rd", 32'(sd_rd), 32'(iss && !m_wr));
        chk("sd_we", 32'(sd_we), 32'(iss && m_wr));
        chk("dl_ack", 32'(dl_ack), 32'(dn && m_src == 1));
        chk("cas_ack", 32'(cas_ack), 32'(dn && m_src == 3));
        chk("cpu_wait", 32'(cpu_wait), 32'(!reset && (m_pend || ((cpu_rd | cpu_we) && !m_prev))));
        chk("cpu_dout", 32'(cpu_dout), 32'(m_cpu_dout));
        chk("cas_dout", 32'(cas_dout), 32'(m_cas_dout));
        chk("sd_addr", 32'(sd_addr), 32'(m_addr));
        chk("sd_din", 32'(sd_din), 32'(m_din));
        if (sd_rd) n_rd++;
        if (sd_we) n_we++;
        if (dl_ack) n_dl++;
        if (cas_ack) n_cas++;
        if (sd_rd || sd_we) begin
            iss_addr.push_back(sd_addr);
            iss_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        int s, r0, w0, d0, c0, q0;
        bit hit;
        // reset values
        tick(3);
        chk("rst cpu_dout", 32'(cpu_dout), 32'h FF);
        chk("rst cas_dout", 32'(cas_dout), 32'h00);
        chk("rst sd_addr", 32'(sd_addr), 32'h0);
        chk("rst sd_din", 32'(sd_din), 32'h0);
        chk("rst cpu_wait", 32'(cpu_wait), 32'h0);
        chk("rst sd_rd", 32'(sd_rd), 32'h0);
        reset = 1'b0;
        tick(2);

        // CPU read
        r0 = n_rd; q0 = iss_addr.size();
        cpu_addr = 18'h01234; cpu_rd = 1'b1; s = cyc;
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!cpu_wait) begin hit = 1; break; end
        end
        chk("rd wait fell", 32'(hit), 32'h1);
        chk("rd wait fall cycle", 32'(cyc - s), 32'd8);
        chk("rd pulses", 32'(n_rd - r0), 32'd1);
        chk("rd addr", 32'(iss_addr[q0]), 32'h01234);
        chk("rd issue cycle", 32'(iss_cyc[q0] - s), 32'd2);
        chk("rd data", 32'(cpu_dout), 32'h A5);
        cpu_rd = 1'b0;
        tick(3);

        // simultaneous download, CPU write and tape
        d0 = n_dl; c0 = n_cas; q0 = iss_addr.size();
        dl_req = 1'b1; cas_req = 1'b1; cas_addr = 18'h30077;
        cpu_addr = 18'h20042; cpu_din = 8'h5A; cpu_we = 1'b1;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (n_dl != d0) dl_req = 1'b0;
            if (n_cas != c0) begin hit = 1; break; end
        end
        cas_req = 1'b0; dl_req = 1'b0; cpu_we = 1'b0;
        chk("sim done", 32'(hit), 32'h1);
        chk("sim issues", 32'(iss_addr.size() - q0), 32'd3);
        chk("sim 1st dl", 32'(iss_addr[q0][17:16]), 32'd1);
        chk("sim 2nd cpu", 32'(iss_addr[q0+1][17:16]), 32'd2);
        chk("sim 3rd cas", 32'(iss_addr[q0+2][17:16]), 32'd3);
        chk("sim spacing a", 32'(iss_cyc[q0+1] - iss_cyc[q0] >= 4), 32'h1);
        chk("sim spacing b", 32'(iss_cyc[q0+2] - iss_cyc[q0+1] >= 4), 32'h1);
        tick(5);

        // starvation: tape waits behind a continuous download stream
        d0 = n_dl; c0 = n_cas; q0 = iss_addr.size();
        dl_req = 1'b1; cas_addr = 18'h30011; cas_req = 1'b1; s = cyc;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (n_cas != c0) begin cas_req = 1'b0; dl_req = 1'b0; hit = 1; break; end
        end
        cas_req = 1'b0; dl_req = 1'b0;
        chk("starve done", 32'(hit), 32'h1);
        chk("starve dl before", 32'(n_dl - d0), 32'd10);
        chk("starve cas addr", 32'(iss_addr[q0+10]), 32'h30011);
        chk("starve cas cycle", 32'(iss_cyc[q0+10] - s), 32'd71);
        tick(10);
        chk("starve cas once", 32'(n_cas - c0), 32'd1);
        chk("starve cas data", 32'(cas_dout), 32'h80);

        // strobe held for 20 cycles
        r0 = n_rd;
        cpu_addr = 18'h011AB; cpu_rd = 1'b1;
        tick(20);
        cpu_rd = 1'b0;
        tick(5);
        chk("hold pulses", 32'(n_rd - r0), 32'd1);
        chk("hold data", 32'(cpu_dout), 32'h3A);

        // read and write rise together
        r0 = n_rd; w0 = n_we;
        cpu_addr = 18'h02200; cpu_din = 8'hC3; cpu_rd = 1'b1; cpu_we = 1'b1;
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!cpu_wait) begin hit = 1; break; end
        end
        cpu_rd = 1'b0; cpu_we = 1'b0;
        chk("rw done", 32'(hit), 32'h1);
        chk("rw we pulses", 32'(n_we - w0), 32'd1);
        chk("rw rd pulses", 32'(n_rd - r0), 32'd0);
        chk("rw dout kept", 32'(cpu_dout), 32'h3A);
        tick(3);

        // reset during WAIT of a tape read
        r0 = n_rd; c0 = n_cas;
        cas_addr = 18'h30055; cas_req = 1'b1;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_rd != r0) begin hit = 1; break; end
        end
        chk("mid issue seen", 32'(hit), 32'h1);
        tick();
        reset = 1'b1; cas_req = 1'b0; cpu_rd = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("mid no ack", 32'(n_cas - c0), 32'd0);
        chk("mid cas_dout", 32'(cas_dout), 32'h00);
        chk("mid no cpu edge", 32'(cpu_wait), 32'h0);
        chk("mid no extra rd", 32'(n_rd - r0), 32'd1);
        q0 = iss_addr.size();
        cas_req = 1'b1; s = cyc;
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (n_cas != c0) begin hit = 1; break; end
        end
        cas_req = 1'b0; cpu_rd = 1'b0;
        chk("post done", 32'(hit), 32'h1);
        chk("post idle grant", 32'(iss_cyc[q0] - s), 32'd1);
        chk("post cas data", 32'(cas_dout), 32'h C4);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
